// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer: writes a zero-padded (WIDTH+2)x(HEIGHT+2) raster of an upstream pixel stream into a channel FIFO
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   valid_in, data_in   upstream pixel stream in raster order
//   ready_out           pixel consumed when valid_in & ready_out
//   fifo_full           downstream FIFO full, stalls all writes
//   wrreq, data_out     FIFO write strobe and word (zero when not writing)
//   frame_done          one-cycle pulse after the last padded word
module featuremap_pad_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 2);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH + 1);
    localparam logic [RW-1:0] R_LAST = RW'(HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic          interior;
    logic          emit;

    always_comb begin
        interior   = (r != '0) && (r != R_LAST) && (c != '0) && (c != C_LAST);
        emit       = (state == EMIT) && !fifo_full;
        ready_out  = emit && interior;
        // border zeros never wait on upstream; interior words need a pixel
        wrreq      = emit && (!interior || valid_in);
        data_out   = (wrreq && interior) ? data_in : '0;
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: state <= valid_in ? EMIT : IDLE;
                EMIT: if (wrreq) begin
                    if (r == R_LAST && c == C_LAST) begin
                        state <= DONE;
                        r     <= '0;
                        c     <= '0;
                    end else if (c == C_LAST) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
